// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder slice.
//   stateT  : controller states (S_IDLE waiting for start, S_RUN shifting bits)
//   clog2() : ceiling log2, used to size the bit counter (minimum 1 bit)
package serial_adder_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } stateT;

    // Width of a counter that must hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int bits;
        int remaining;
        bits = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            bits = bits + 1;
            remaining = remaining >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell
// Purely combinational single-bit full adder used by serial_adder for every
// bit-step. The carry storage lives in the parent, not here.
// Ports:
//   bitA, bitB : operand bits
//   carryIn    : carry from the previous bit-step
//   sumBit     : bitA ^ bitB ^ carryIn
//   carryOut   : majority of the three inputs
module full_adder_cell (
    input  logic bitA,
    input  logic bitB,
    input  logic carryIn,
    output logic sumBit,
    output logic carryOut
);

    assign sumBit   = bitA ^ bitB ^ carryIn;
    assign carryOut = (bitA & bitB) | (bitA & carryIn) | (bitB & carryIn);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: captures a WIDTH-bit operand pair on an accepted start,
// adds one bit per clock LSB first, then registers sum, carry-out and signed
// overflow together with a single-cycle done strobe. Latency is WIDTH clocks.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port; with sub = 1
// at accept the block computes a - b (B inverted, carry forced to 1).
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request, only looked at while idle
//   a, b, cin    : operands and carry-in, captured on the accept edge
//   sub          : subtract select (SERIAL_ADDER_SUB_EN builds only)
//   busy         : high while bit-steps are in progress
//   done         : one-cycle strobe, results valid
//   sum          : WIDTH-bit result, held until the next result is ready
//   cout         : carry out of the MSB
//   overflow     : carry into MSB xor carry out of MSB
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] shiftA;
    logic [WIDTH-1:0] shiftB;
    logic [WIDTH-1:0] sumShift;
    logic [WIDTH-1:0] sumNext;
    logic             carry;
    logic [CW-1:0]    bitCount;
    logic             stepSum;
    logic             stepCarry;
    logic             accept;
    logic             lastStep;
    logic [WIDTH-1:0] loadB;
    logic             loadCarry;

    // Operand conditioning at accept: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        loadB     = sub ? ~b : b;
        loadCarry = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        loadB     = b;
        loadCarry = cin;
    end
`endif

    full_adder_cell uCell (
        .bitA     (shiftA[0]),
        .bitB     (shiftB[0]),
        .carryIn  (carry),
        .sumBit   (stepSum),
        .carryOut (stepCarry)
    );

    // New sum bit enters at the MSB; after WIDTH steps the LSB has arrived at bit 0.
    assign sumNext = {stepSum, {(WIDTH-1){1'b0}}} | (sumShift >> 1);

    assign busy = (state == S_RUN);

    // Next-state logic: accept only from idle, leave run after the final bit-step.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        lastStep  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    stateNext = S_RUN;
                end
            end
            S_RUN: begin
                if (bitCount == LAST_STEP) begin
                    lastStep  = 1'b1;
                    stateNext = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath: load on accept, shift and count while running, and publish
    // results only on the last step so no partial sum is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftA   <= '0;
            shiftB   <= '0;
            sumShift <= '0;
            carry    <= 1'b0;
            bitCount <= '0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shiftA   <= a;
                shiftB   <= loadB;
                carry    <= loadCarry;
                bitCount <= '0;
                sumShift <= '0;
            end else if (state == S_RUN) begin
                shiftA   <= shiftA >> 1;
                shiftB   <= shiftB >> 1;
                sumShift <= sumNext;
                carry    <= stepCarry;
                bitCount <= bitCount + CW'(1);
                if (lastStep) begin
                    sum      <= sumNext;
                    cout     <= stepCarry;
                    overflow <= carry ^ stepCarry;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed bench for serial_adder at WIDTH = 8: arithmetic corner cases,
// done timing, start-while-busy, back-to-back start, and async reset mid-run.
// Subtract vectors are included when built with SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int total;
    int bad;
    int edges;
    int doneCount;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected)
        else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands with start high across one rising edge (the accept edge).
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        sub   = sv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full operation: accept, wait for done (bounded), check results and strobe width.
    task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic sv, input logic [7:0] expSum, input logic expCout, input logic expOvf);
        applyStimulus(av, bv, cv, sv);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges = edges + 1;
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'd8);
        checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
        checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(expOvf));
        checkOutput({tag, " busyLow"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " donePulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        edges     = 0;
        doneCount = 0;

        // Reset state
        #12;
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst sum", 32'(sum), 32'd0);
        checkOutput("rst cout", 32'(cout), 32'd0);
        checkOutput("rst ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic corner cases
        runOp("0F+01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        runOp("FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        runOp("FF+00+c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        runOp("7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        runOp("80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
        doneCount = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (done) doneCount = doneCount + 1;
            if (k == 2) begin
                a     = 8'h55;
                b     = 8'hAA;
                cin   = 1'b1;
                start = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (k == 4) checkOutput("busyStart heldSum", 32'(sum), 32'h00);
        end
        checkOutput("busyStart doneCount", 32'(doneCount), 32'd1);
        checkOutput("busyStart sum", 32'(sum), 32'h10);
        a     = 8'h7F;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b accepted", 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges = edges + 1;
        end
        checkOutput("b2b latency", 32'(edges), 32'd8);
        checkOutput("b2b sum", 32'(sum), 32'h80);
        checkOutput("b2b ovf", 32'(overflow), 32'd1);
        checkOutput("b2b cout", 32'(cout), 32'd0);

        // Asynchronous reset mid-operation
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst busy", 32'(busy), 32'd0);
        checkOutput("midRst done", 32'(done), 32'd0);
        checkOutput("midRst sum", 32'(sum), 32'd0);
        checkOutput("midRst cout", 32'(cout), 32'd0);
        checkOutput("midRst ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) doneCount = doneCount + 1;
        end
        checkOutput("midRst noDone", 32'(doneCount), 32'd0);
        runOp("afterRst", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction: a + ~b + 1, carry-in ignored
        runOp("05-07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        runOp("80-01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
